// File: rtl/demux_rr_sched_if.sv
// Control/status bundle between a slot-sequence controller and the
// round-robin demux scheduler.
interface demux_rr_sched_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic [7:0]         en_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               route_en;
  logic               busy;
  logic               slot_done;
  logic               frame_done;

  // Controller side: issues commands, observes the schedule.
  modport master (
    output start, stop, en_mask, dwell,
    input  sel, route_en, busy, slot_done, frame_done
  );

  // Scheduler side.
  modport slave (
    input  start, stop, en_mask, dwell,
    output sel, route_en, busy, slot_done, frame_done
  );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin slot scheduler for the 8-way demux select. Walks sel through
// the enabled outputs in ascending order, holding each for dwell+1 cycles,
// and flags slot and frame boundaries.
module demux_rr_sched #(
  parameter int DWELL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  demux_rr_sched_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [2:0]         sel_q;
  logic [DWELL_W-1:0] cnt;
  logic [7:0]         mask_q;
  logic               stop_pend;

  logic [3:0]         nxt;
  logic               slot_last;

  // Index of the lowest set bit; 0 for an empty mask (callers guard that case).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_bit = 3'(k);
    end
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    next_above = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k > int'(cur))) next_above = {1'b1, 3'(k)};
    end
  endfunction

  assign nxt       = next_above(mask_q, sel_q);
  assign slot_last = (state == RUN) && (cnt == '0);

  assign bus.sel        = sel_q;
  assign bus.route_en   = (state == RUN);
  assign bus.busy       = (state == RUN);
  assign bus.slot_done  = slot_last;
  assign bus.frame_done = slot_last && !nxt[3];

  // Run/idle sequencing, slot countdown and frame-boundary mask reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= 3'd0;
      cnt       <= '0;
      mask_q    <= 8'd0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (bus.en_mask != 8'd0)) begin
            mask_q    <= bus.en_mask;
            sel_q     <= lowest_bit(bus.en_mask);
            cnt       <= bus.dwell;
            stop_pend <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (stop_pend || bus.stop) begin
            // Graceful stop: sel keeps the value of the slot just finished.
            state <= IDLE;
          end else if (!nxt[3]) begin
            // Frame boundary: the new mask only takes effect here.
            mask_q <= bus.en_mask;
            if (bus.en_mask == 8'd0) begin
              state <= IDLE;
            end else begin
              sel_q <= lowest_bit(bus.en_mask);
              cnt   <= bus.dwell;
            end
          end else begin
            sel_q <= nxt[2:0];
            cnt   <= bus.dwell;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: a frame/slot-queue reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_demux_rr_sched;

  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  demux_rr_sched_if #(.DWELL_W(DWELL_W)) bus ();

  demux_rr_sched #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a run is a sequence of frames; each frame is the list of
  // enabled indices captured at its start, and each slot lasts dwell+1 cycles.
  bit m_run;
  int m_sel;
  int m_left;
  int m_queue[$];
  bit m_stop;

  task automatic model_reset();
    m_run = 0; m_sel = 0; m_left = 0; m_stop = 0;
    m_queue.delete();
  endtask

  task automatic load_frame(input logic [7:0] m, input int dw);
    m_queue.delete();
    for (int k = 0; k < 8; k++) if (m[k]) m_queue.push_back(k);
    m_sel  = m_queue.pop_front();
    m_left = dw + 1;
  endtask

  task automatic model_step();
    bit stopreq;
    if (!m_run) begin
      if (bus.start && bus.en_mask != 0) begin
        load_frame(bus.en_mask, int'(bus.dwell));
        m_run  = 1;
        m_stop = 0;
      end
    end else begin
      stopreq = m_stop || bus.stop;
      if (bus.stop) m_stop = 1;
      if (m_left > 1) m_left--;
      else if (stopreq) m_run = 0;
      else if (m_queue.size() == 0) begin
        if (bus.en_mask == 0) m_run = 0;
        else load_frame(bus.en_mask, int'(bus.dwell));
      end else begin
        m_sel  = m_queue.pop_front();
        m_left = int'(bus.dwell) + 1;
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    bit sd;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      sd = m_run && (m_left == 1);
      check("m_sel",        int'(bus.sel),        m_run || 1 ? m_sel : 0);
      check("m_route_en",   int'(bus.route_en),   int'(m_run));
      check("m_busy",       int'(bus.busy),       int'(m_run));
      check("m_slot_done",  int'(bus.slot_done),  int'(sd));
      check("m_frame_done", int'(bus.frame_done), int'(sd && m_queue.size() == 0));
      if (!reset) model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      cyc();
      n++;
    end
    check("wait_idle", int'(bus.busy), 0);
  endtask

  int sparse_sel[10] = '{2, 2, 2, 5, 5, 5, 7, 7, 7, 2};

  initial begin
    bus.start = 0; bus.stop = 0; bus.en_mask = 8'h00; bus.dwell = '0;
    repeat (3) cyc();
    check("rst_sel", int'(bus.sel), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_route_en", int'(bus.route_en), 0);
    check("rst_slot_done", int'(bus.slot_done), 0);
    reset = 0;
    cyc();

    // Full mask, single-cycle slots.
    bus.en_mask = 8'hFF; bus.dwell = 4'd0; bus.start = 1;
    cyc();
    bus.start = 0;
    check("basic_sel0", int'(bus.sel), 0);
    check("basic_busy", int'(bus.busy), 1);
    check("basic_fd0", int'(bus.frame_done), 0);
    for (int k = 1; k < 8; k++) begin
      cyc();
      check("basic_sel", int'(bus.sel), k);
      check("basic_route", int'(bus.route_en), 1);
      check("basic_fd", int'(bus.frame_done), (k == 7) ? 1 : 0);
    end
    cyc();
    check("basic_wrap", int'(bus.sel), 0);
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    check("basic_stop_busy", int'(bus.busy), 0);
    check("basic_stop_sel", int'(bus.sel), 0);

    // Sparse mask, three-cycle slots.
    bus.en_mask = 8'b1010_0100; bus.dwell = 4'd2; bus.start = 1;
    cyc();
    bus.start = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      check("sparse_sel", int'(bus.sel), sparse_sel[i]);
      check("sparse_sd", int'(bus.slot_done), (i % 3 == 2) ? 1 : 0);
      check("sparse_fd", int'(bus.frame_done), (i == 8) ? 1 : 0);
    end
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    wait_idle(10);
    check("sparse_hold", int'(bus.sel), 2);

    // Mask change mid-frame and empty mask at a boundary.
    bus.en_mask = 8'h0F; bus.dwell = 4'd0; bus.start = 1;
    cyc();
    bus.start = 0;
    check("mchg_sel0", int'(bus.sel), 0);
    cyc();
    check("mchg_sel1", int'(bus.sel), 1);
    bus.en_mask = 8'h30;
    cyc();
    check("mchg_sel2", int'(bus.sel), 2);
    cyc();
    check("mchg_sel3", int'(bus.sel), 3);
    check("mchg_fd3", int'(bus.frame_done), 1);
    cyc();
    check("mchg_sel4", int'(bus.sel), 4);
    check("mchg_fd4", int'(bus.frame_done), 0);
    cyc();
    check("mchg_sel5", int'(bus.sel), 5);
    check("mchg_fd5", int'(bus.frame_done), 1);
    bus.en_mask = 8'h00;
    cyc();
    check("mchg_idle", int'(bus.busy), 0);
    check("mchg_hold", int'(bus.sel), 5);

    // Graceful stop requested on the second cycle of a six-cycle slot.
    bus.en_mask = 8'h06; bus.dwell = 4'd5; bus.start = 1;
    cyc();
    bus.start = 0;
    check("gstop_sel", int'(bus.sel), 1);
    cyc();
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    check("gstop_busy2", int'(bus.busy), 1);
    repeat (3) cyc();
    check("gstop_sd", int'(bus.slot_done), 1);
    check("gstop_sel5", int'(bus.sel), 1);
    cyc();
    check("gstop_busy", int'(bus.busy), 0);
    check("gstop_route", int'(bus.route_en), 0);
    check("gstop_hold", int'(bus.sel), 1);
    bus.start = 1;
    cyc();
    bus.start = 0;
    check("gstop_restart", int'(bus.busy), 1);
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    wait_idle(20);

    // Single enabled output; start and stop together in IDLE.
    bus.en_mask = 8'h40; bus.dwell = 4'd1; bus.start = 1; bus.stop = 1;
    cyc();
    bus.start = 0; bus.stop = 0;
    check("single_busy", int'(bus.busy), 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      check("single_sel", int'(bus.sel), 6);
      check("single_sd", int'(bus.slot_done), i % 2);
      check("single_fd", int'(bus.frame_done), i % 2);
    end
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    wait_idle(10);
    bus.en_mask = 8'h00; bus.start = 1;
    repeat (2) cyc();
    check("empty_start", int'(bus.busy), 0);
    bus.start = 0;

    // Asynchronous reset in the middle of a sel=5 slot.
    bus.en_mask = 8'h20; bus.dwell = 4'd3; bus.start = 1;
    cyc();
    bus.start = 0;
    cyc();
    check("arst_pre_sel", int'(bus.sel), 5);
    check("arst_pre_busy", int'(bus.busy), 1);
    #2 reset = 1;
    #1;
    check("arst_sel", int'(bus.sel), 0);
    check("arst_route", int'(bus.route_en), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_sd", int'(bus.slot_done), 0);
    check("arst_fd", int'(bus.frame_done), 0);
    repeat (2) cyc();
    reset = 0;
    repeat (3) cyc();
    check("arst_stay_idle", int'(bus.busy), 0);
    check("arst_stay_sel", int'(bus.sel), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
